sysid_reader: RTL

Avalon-MM read master that interrogates a system-ID peripheral (word 0 = system ID, word 1 = build timestamp) and reports whether the hardware matches the build the software expects. It sits next to the Nios II system as a hardware self-check: after reset, or on a `start` pulse, it issues two reads over the system-ID control slave port. It compares the returned words against parameters and raises sticky status flags for a board-level LED or for the CPU.

---
 rtl/sysid_reader_pkg.sv | 30 +++
 rtl/sysid_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sysid_reader_pkg.sv
// sysid_reader_pkg
//   Shared types and constants for the system-ID self-check reader.
//   - sysid_rd_state_t : read-sequence FSM states
//   - SYSID_ADDR_ID/TS : word addresses on the system-ID control slave
//   - clog2()          : ceiling log2, used to size the timeout counter
package sysid_reader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    DONE  = 3'd5
  } sysid_rd_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sysid_reader.sv
// sysid_reader
//   Avalon-MM read master that reads the system-ID peripheral (word 0 = ID,
//   word 1 = build timestamp) after reset or on a start pulse, compares both
//   words against the expected build and holds sticky status flags.
//
// Ports
//   clock, reset        : single clock, asynchronous active-high reset
//   start               : launch a check (ignored while busy)
//   m_address, m_read   : read request towards the system-ID slave
//   m_waitrequest       : slave stall
//   m_readdata/valid    : read response
//   busy, done, pass    : check progress and sticky result
//   id_mismatch, ts_mismatch, timeout : sticky error flags
//   id_value, ts_value  : last captured words
//   dbg_state           : current FSM state (observation only)
//
// Handshake: a read is requested by holding m_read=1 with a stable
// m_address; it is accepted on a rising edge where m_read=1 and
// m_waitrequest=0. The response is the first m_readdatavalid=1 cycle seen
// while waiting for that read; valid pulses in any other state are dropped.
module sysid_reader
  import sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1532083560,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic            m_address,
  output logic            m_read,
  input  logic            m_waitrequest,
  input  logic [31:0]     m_readdata,
  input  logic            m_readdatavalid,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            id_mismatch,
  output logic            ts_mismatch,
  output logic            timeout,
  output logic [31:0]     id_value,
  output logic [31:0]     ts_value,
  output sysid_rd_state_t dbg_state
);

  localparam int CNT_RAW = clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W:0] CNT_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  sysid_rd_state_t state_q, state_d;
  logic             auto_q, auto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             expire;
  logic             m_read_q, m_read_d;
  logic             m_address_q, m_address_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             id_mis_q, id_mis_d;
  logic             ts_mis_q, ts_mis_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      id_value_q, id_value_d;
  logic [31:0]      ts_value_q, ts_value_d;

  // cnt_q counts cycles already spent on the current read, so the current
  // cycle is number cnt_q+1. The read expires on the cycle that would make
  // TIMEOUT_CYCLES; the counter saturates rather than wrapping.
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_sat = cnt_inc[CNT_W] ? cnt_q : cnt_inc[CNT_W-1:0];
  assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc >= CNT_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      auto_q      <= AUTO_START;
      cnt_q       <= '0;
      m_read_q    <= 1'b0;
      m_address_q <= SYSID_ADDR_ID;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      id_mis_q    <= 1'b0;
      ts_mis_q    <= 1'b0;
      timeout_q   <= 1'b0;
      id_value_q  <= '0;
      ts_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      auto_q      <= auto_d;
      cnt_q       <= cnt_d;
      m_read_q    <= m_read_d;
      m_address_q <= m_address_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      id_mis_q    <= id_mis_d;
      ts_mis_q    <= ts_mis_d;
      timeout_q   <= timeout_d;
      id_value_q  <= id_value_d;
      ts_value_q  <= ts_value_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    auto_d     = 1'b0;  // auto-start only ever fires on the first cycle
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    id_mis_d   = id_mis_q;
    ts_mis_d   = ts_mis_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    if ((state_q == RD_ID) || (state_q == WT_ID) ||
        (state_q == RD_TS) || (state_q == WT_TS)) begin
      cnt_d = cnt_sat;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start || auto_q) begin
          state_d   = RD_ID;
          cnt_d     = '0;
          pass_d    = 1'b0;
          id_mis_d  = 1'b0;
          ts_mis_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      RD_ID: begin
        // An accept on the expiry cycle still carries no data: timeout wins.
        if (expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (!m_waitrequest) begin
          state_d = WT_ID;
        end
      end
      WT_ID: begin
        // Data on the expiry cycle beats the timeout.
        if (m_readdatavalid) begin
          id_value_d = m_readdata;
          id_mis_d   = (m_readdata != EXPECTED_ID);
          state_d    = RD_TS;
          cnt_d      = '0;
        end else if (expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      RD_TS: begin
        if (expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (!m_waitrequest) begin
          state_d = WT_TS;
        end
      end
      WT_TS: begin
        if (m_readdatavalid) begin
          ts_value_d = m_readdata;
          ts_mis_d   = (m_readdata != EXPECTED_TS);
          state_d    = DONE;
        end else if (expire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Verdict is taken once, on entry to DONE, from the flags as they will
    // be after this cycle's capture.
    if ((state_d == DONE) && (state_q != DONE)) begin
      pass_d = !id_mis_d && !(CHECK_TS && ts_mis_d) && !timeout_d;
    end

    // Bus and status outputs are registered from the next state so they line
    // up with the state they describe.
    m_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    m_address_d = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d      = m_read_d || (state_d == WT_ID) || (state_d == WT_TS);
    done_d      = (state_d == DONE);
  end

  assign m_address   = m_address_q;
  assign m_read      = m_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign dbg_state   = state_q;

endmodule
